iserdes_window_capture: RTL

Triggered capture buffer directly downstream of the 16-lane DDR deserializer. It takes the 128-bit parallel word the deserializer produces every rxclkdiv cycle once its training has completed. It holds a programmable pre-trigger history in a circular RAM, records a programmable post-trigger tail, then streams the window out over a valid/ready interface to the readout FIFO.

---
 rtl/iserdes_window_capture.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/iserdes_window_capture.sv
// rtl/iserdes_window_capture.sv - triggered pre/post window capture buffer behind the 16-lane deserializer
// Circular RAM keeps history; a trigger freezes a window that is then streamed out with valid/ready.
module iserdes_window_capture #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 6
) (
  input  logic              rxclkdiv,
  input  logic              rst_n,
  input  logic              training_done,
  input  logic [DATA_W-1:0] data_in,
  input  logic              arm,
  input  logic              trig,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W:0]   post_len,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              armed,
  output logic              cfg_err,
  output logic              abort
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] r_wp;
  logic [ADDR_W-1:0] r_pre;
  logic [ADDR_W-1:0] r_raddr;
  logic [ADDR_W:0]   r_post;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   r_rd_left;
  logic              r_cfg_err;
  logic              r_abort;

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic [DATA_W-1:0] r_pf_data;
  logic              r_pf_valid;
  logic              r_pf_last;

  logic [ADDR_W+1:0] w_win_len;
  logic              w_cfg_ok;
  logic              w_arm_req;
  logic              w_arm_ok;
  logic              w_capture;
  logic              w_lost;
  logic              w_fill_done;
  logic              w_post_done;
  logic              w_pop;
  logic              w_issue;
  logic              w_rd_last;
  logic [DATA_W-1:0] w_rdata;

  // Sum is two bits wider than the address so pre_len + post_len can never wrap.
  assign w_win_len   = {2'b00, pre_len} + {1'b0, post_len};
  assign w_cfg_ok    = (post_len != '0) && (w_win_len <= (ADDR_W+2)'(DEPTH));
  assign w_arm_req   = (r_state == S_IDLE) && arm && training_done;
  assign w_arm_ok    = w_arm_req && w_cfg_ok;
  assign w_capture   = (r_state == S_FILL) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_lost      = w_capture && !training_done;
  assign w_fill_done = (r_pre == '0) || (r_cnt == ({1'b0, r_pre} - (ADDR_W+1)'(1)));
  assign w_post_done = (r_cnt == (r_post - (ADDR_W+1)'(1)));

  assign w_pop     = r_out_valid && out_ready;
  // Read only when the output register plus prefetch slot can absorb the word this edge.
  assign w_issue   = (r_state == S_READ) && (r_rd_left != '0) &&
                     !(r_out_valid && r_pf_valid && !w_pop);
  assign w_rd_last = (r_rd_left == (ADDR_W+1)'(1));
  assign w_rdata   = r_mem[r_raddr];

  always_ff @(posedge rxclkdiv or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_arm_ok) begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        if (!training_done) begin
          w_next = S_IDLE;
        end else if (w_fill_done) begin
          w_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!training_done) begin
          w_next = S_IDLE;
        end else if (trig) begin
          w_next = (r_post == (ADDR_W+1)'(1)) ? S_READ : S_POST;
        end
      end
      S_POST: begin
        if (!training_done) begin
          w_next = S_IDLE;
        end else if (w_post_done) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        if (w_pop && r_out_last) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    armed = 1'b0;
    busy  = (r_state != S_IDLE);
    armed = (r_state == S_ARMED);
  end

  always_ff @(posedge rxclkdiv) begin
    if (w_capture) begin
      r_mem[r_wp] <= data_in;
    end
  end

  always_ff @(posedge rxclkdiv or negedge rst_n) begin
    if (!rst_n) begin
      r_wp      <= '0;
      r_pre     <= '0;
      r_post    <= '0;
      r_cnt     <= '0;
      r_raddr   <= '0;
      r_rd_left <= '0;
      r_cfg_err <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_cfg_err <= w_arm_req && !w_cfg_ok;

      if (w_arm_ok) begin
        r_pre   <= pre_len;
        r_post  <= post_len;
        r_cnt   <= '0;
        r_abort <= 1'b0;
      end

      if (w_lost) begin
        r_abort <= 1'b1;
      end

      if (w_capture) begin
        r_wp <= r_wp + 1'b1;
      end

      case (r_state)
        S_FILL: begin
          r_cnt <= w_fill_done ? '0 : r_cnt + 1'b1;
        end
        S_ARMED: begin
          if (trig) begin
            // The trigger word sits at r_wp; the window starts pre_len words earlier.
            r_cnt     <= (ADDR_W+1)'(1);
            r_raddr   <= r_wp - r_pre;
            r_rd_left <= {1'b0, r_pre} + r_post;
          end
        end
        S_POST: begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
        end
      endcase

      if (w_issue) begin
        r_raddr   <= r_raddr + 1'b1;
        r_rd_left <= r_rd_left - 1'b1;
      end
    end
  end

  always_ff @(posedge rxclkdiv or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_pf_data   <= '0;
      r_pf_valid  <= 1'b0;
      r_pf_last   <= 1'b0;
    end else if (r_state != S_READ) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_pf_valid  <= 1'b0;
    end else if (!r_out_valid || w_pop) begin
      if (r_pf_valid) begin
        r_out_data  <= r_pf_data;
        r_out_last  <= r_pf_last;
        r_out_valid <= 1'b1;
        r_pf_valid  <= w_issue;
        r_pf_data   <= w_rdata;
        r_pf_last   <= w_rd_last;
      end else begin
        r_out_valid <= w_issue;
        r_out_last  <= w_issue && w_rd_last;
        if (w_issue) begin
          r_out_data <= w_rdata;
        end
      end
    end else if (w_issue) begin
      r_pf_data  <= w_rdata;
      r_pf_last  <= w_rd_last;
      r_pf_valid <= 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign cfg_err   = r_cfg_err;
  assign abort     = r_abort;

endmodule
